// File: rtl/prod_sum_result_buf.sv
// Result buffer between the pipelined multiply-accumulate and its consumer: circular FIFO of {sum, tag}.
// Optional tag-sequence checker compiled in with `define PROD_SUM_RESULT_BUF_ID_CHK_EN.
module prod_sum_result_buf #(
    parameter int sum_width = 17,
    parameter int id_width  = 8,
    parameter int depth     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arrive,
    input  logic [id_width-1:0]          arrive_id,
    input  logic [sum_width-1:0]         sum,
    output logic                         accept_n,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [sum_width-1:0]         out_sum,
    output logic [id_width-1:0]          out_id,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         id_err
);
    localparam int ptr_w   = $clog2(depth);
    localparam int cnt_w   = $clog2(depth + 1);
    localparam int entry_w = sum_width + id_width;

    logic [entry_w-1:0] mem [depth];
    logic [ptr_w-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [ptr_w-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [cnt_w-1:0]   count_reg, count_next;
    logic [entry_w-1:0] head_reg;
    logic               full, push, pop;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(depth - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    // Backpressure comes from the registered count only; a same-cycle pop never frees a slot.
    assign full      = (count_reg == cnt_w'(depth));
    assign accept_n  = full;
    assign out_valid = (count_reg != '0);
    assign push      = arrive & ~full;
    assign pop       = out_valid & out_ready;

    assign count   = count_reg;
    assign out_sum = head_reg[entry_w-1:id_width];
    assign out_id  = head_reg[id_width-1:0];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
        if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
        case ({push, pop})
            2'b10:   count_next = count_reg + cnt_w'(1);
            2'b01:   count_next = count_reg - cnt_w'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= {sum, arrive_id};
    end

    // The head register is a registered read of the next head slot; it bypasses the
    // incoming write when that write lands in the slot that becomes the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (count_next != '0) begin
                if (push && (rd_ptr_next == wr_ptr_reg))
                    head_reg <= {sum, arrive_id};
                else
                    head_reg <= mem[rd_ptr_next];
            end
        end
    end

`ifdef PROD_SUM_RESULT_BUF_ID_CHK_EN
    logic                have_ref_reg;
    logic [id_width-1:0] last_id_reg;
    logic                id_err_reg;
    logic [id_width-1:0] expect_id;

    assign expect_id = last_id_reg + id_width'(1);
    assign id_err    = id_err_reg;

    // First accepted tag after reset only seeds the reference; the error is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            have_ref_reg <= 1'b0;
            last_id_reg  <= '0;
            id_err_reg   <= 1'b0;
        end else if (push) begin
            have_ref_reg <= 1'b1;
            last_id_reg  <= arrive_id;
            if (have_ref_reg && (arrive_id != expect_id))
                id_err_reg <= 1'b1;
        end
    end
`else
    assign id_err = 1'b0;
`endif

endmodule

// File: tb/tb_prod_sum_result_buf.sv
// Scoreboard bench for prod_sum_result_buf: driver pushes expectations, negedge monitor pops and compares.
module tb_prod_sum_result_buf;
    localparam int SW    = 17;
    localparam int IW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef PROD_SUM_RESULT_BUF_ID_CHK_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arrive = 1'b0;
    logic [IW-1:0] arrive_id = '0;
    logic [SW-1:0] sum_in = '0;
    logic          accept_n;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_sum;
    logic [IW-1:0] out_id;
    logic [CW-1:0] count;
    logic          id_err;

    prod_sum_result_buf #(.sum_width(SW), .id_width(IW), .depth(DEPTH)) dut (
        .clk(clk), .rst(rst), .arrive(arrive), .arrive_id(arrive_id), .sum(sum_in),
        .accept_n(accept_n), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_id(out_id), .count(count), .id_err(id_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: queue of expected entries plus tag-sequence state.
    logic [SW+IW-1:0] exp_q[$];
    int               model_count = 0;
    bit               model_err   = 1'b0;
    bit               err_st      = 1'b0;
    bit               have_ref    = 1'b0;
    logic [IW-1:0]    last_id     = '0;
    bit               chk_en      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit arr, input logic [IW-1:0] id, input logic [SW-1:0] s, input bit rdy);
        logic [IW-1:0] nxt;
        @(posedge clk); #1;
        rst = 1'b0; arrive = arr; arrive_id = id; sum_in = s; out_ready = rdy; chk_en = 1'b1;
        model_count = exp_q.size();
        model_err   = err_st;
        if (arr && exp_q.size() < DEPTH) begin
            exp_q.push_back({s, id});
            nxt = last_id + 8'd1;
            if (CHK_ON && have_ref && id != nxt) err_st = 1'b1;
            have_ref = 1'b1;
            last_id  = id;
        end
    endtask

    task automatic do_reset(input bit arr);
        @(posedge clk); #1;
        rst = 1'b1; arrive = arr; arrive_id = IW'($urandom); sum_in = SW'($urandom);
        out_ready = 1'($urandom); chk_en = 1'b0;
        exp_q.delete(); err_st = 1'b0; have_ref = 1'b0; last_id = '0;
        @(posedge clk); #1;
        rst = 1'b0; arrive = 1'b0; out_ready = 1'b0;
        model_count = 0; model_err = 1'b0; chk_en = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_accept_n", 32'(accept_n), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_id_err", 32'(id_err), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(count), 32'(model_count));
            chk("accept_n", 32'(accept_n), 32'(model_count == DEPTH));
            chk("out_valid", 32'(out_valid), 32'(model_count != 0));
            chk("id_err", 32'(id_err), 32'(model_err));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("[TB] FAIL pop_empty: got id 0x%0h expected no entry", out_id);
                end else begin
                    logic [SW+IW-1:0] e;
                    e = exp_q.pop_front();
                    chk("out_id", 32'(out_id), 32'(e[IW-1:0]));
                    chk("out_sum", 32'(out_sum), 32'(e[SW+IW-1:IW]));
                    $display("[TB] pop id=0x%02h sum=0x%05h", out_id, out_sum);
                end
            end
        end
    end

    initial begin
        logic [IW-1:0] nid;
        int rdy_pct;
        do_reset(1'b0);

        // single push, one-cycle latency
        cycle(1'b1, 8'h05, 17'h1ABCD, 1'b0);
        cycle(1'b0, 8'h00, 17'h0, 1'b0);
        chk("lat_out_id", 32'(out_id), 32'h05);
        chk("lat_out_sum", 32'(out_sum), 32'h1ABCD);
        chk("lat_count", 32'(count), 32'd1);
        cycle(1'b0, 8'h00, 17'h0, 1'b1);

        // fill, reject fifth, drain in order
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, IW'(i), SW'($urandom), 1'b0);
        cycle(1'b1, 8'h04, SW'($urandom), 1'b0);
        chk("full_accept_n", 32'(accept_n), 32'd1);
        chk("full_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 17'h0, 1'b1);
        cycle(1'b0, 8'h00, 17'h0, 1'b0);
        chk("drain_count", 32'(count), 32'd0);

        // full with simultaneous arrive and pop
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, IW'(i), SW'($urandom), 1'b0);
        cycle(1'b1, 8'h04, SW'($urandom), 1'b1);
        cycle(1'b0, 8'h00, 17'h0, 1'b0);
        chk("fullpop_count", 32'(count), 32'd3);
        chk("fullpop_accept_n", 32'(accept_n), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 17'h0, 1'b1);

        // steady-state streaming across pointer wrap
        do_reset(1'b0);
        cycle(1'b1, 8'h00, SW'($urandom), 1'b0);
        cycle(1'b1, 8'h01, SW'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, IW'(i + 2), SW'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 17'h0, 1'b1);

        // reset mid-operation with arrive asserted
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, IW'(i), SW'($urandom), 1'b0);
        do_reset(1'b1);

        // tag-sequence checker
        do_reset(1'b0);
        cycle(1'b1, 8'h10, SW'($urandom), 1'b1);
        cycle(1'b1, 8'h11, SW'($urandom), 1'b1);
        cycle(1'b1, 8'h13, SW'($urandom), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 17'h0, 1'b1);
        do_reset(1'b0);
        cycle(1'b1, 8'hFF, SW'($urandom), 1'b1);
        cycle(1'b1, 8'h00, SW'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 17'h0, 1'b1);

        // randomized traffic with occasional tag skips and resets
        for (int seg = 0; seg < 4; seg++) begin
            do_reset(1'b0);
            nid = IW'($urandom);
            rdy_pct = 20 + seg * 25;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 199) == 0) begin
                    do_reset(1'($urandom));
                end else begin
                    bit a;
                    a = ($urandom_range(0, 99) < 60);
                    cycle(a, nid, SW'($urandom), $urandom_range(0, 99) < rdy_pct);
                    if (a && !accept_n) nid = nid + ((seg == 3 && $urandom_range(0, 29) == 0) ? 8'd2 : 8'd1);
                end
            end
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 17'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
